// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: mode encodings and FSM states.
// Imported by alu_sequencer and alu_mul_seq.
package alu_pkg;

    localparam logic [2:0] MODE_ADD = 3'b000;
    localparam logic [2:0] MODE_SUB = 3'b001;
    localparam logic [2:0] MODE_AND = 3'b010;
    localparam logic [2:0] MODE_OR  = 3'b011;
    localparam logic [2:0] MODE_XOR = 3'b100;
    localparam logic [2:0] MODE_SHL = 3'b101;
    localparam logic [2:0] MODE_SHR = 3'b110;
    localparam logic [2:0] MODE_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_MUL,
        ST_RESP
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add 8x8 unsigned multiplier, one partial product per cycle.
// Ports: clk_i, rst_i (async high), start_i clears, step_i advances,
//        a_i/b_i operands, product_o running sum incl. this step, done_o.
module alu_mul_seq
    import alu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        step_i,
    input  logic [7:0]  a_i,
    input  logic [7:0]  b_i,
    output logic [15:0] product_o,
    output logic        done_o
);

    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] term;
    logic [15:0] sum;

    always_comb begin
        term = '0;
        if (b_i[cnt_q]) begin
            term = {8'h00, a_i} << cnt_q;
        end
        sum = acc_q + term;

        cnt_d = cnt_q;
        acc_d = acc_q;
        if (start_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (step_i) begin
            // cnt wraps to 0 after the last bit, ready for the next op
            cnt_d = cnt_q + 3'd1;
            acc_d = sum;
        end
    end

    // product_o includes the current step so the final bit is not lost
    assign product_o = sum;
    assign done_o    = step_i && (cnt_q == 3'd7);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one request at a time through an external ALU or the
// internal shift-add multiplier. Ports: req_* in, rsp_* out, alu_* drive,
// alu_result from the combinational ALU, busy when not IDLE.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int MUL_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_a,
    input  logic [7:0]  req_b,
    input  logic [2:0]  req_mode,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [2:0]  alu_mode,
    input  logic [15:0] alu_result,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_result,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [7:0]  a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [2:0]  mode_q, mode_d;
    logic [15:0] res_q, res_d;
    logic        mul_start;
    logic        mul_step;
    logic        mul_done;
    logic [15:0] mul_product;

    alu_mul_seq u_mul (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (mul_start),
        .step_i    (mul_step),
        .a_i       (a_q),
        .b_i       (b_q),
        .product_o (mul_product),
        .done_o    (mul_done)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        res_d     = res_q;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    a_d       = req_a;
                    b_d       = req_b;
                    mode_d    = req_mode;
                    mul_start = 1'b1;
                    if (req_mode == MODE_MUL && MUL_EN != 0) begin
                        state_d = ST_MUL;
                    end else begin
                        state_d = ST_DRIVE;
                    end
                end
            end
            ST_DRIVE: begin
                res_d   = alu_result;
                state_d = ST_RESP;
            end
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_done) begin
                    res_d   = mul_product;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_ADD;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_valid  = (state_q == ST_RESP);
    assign rsp_result = res_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_mode   = mode_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer (MUL_EN=1 and MUL_EN=0 instances)
// driving a behavioural 8-bit ALU with 16-bit result.
module tb_alu_sequencer;

    typedef struct {
        logic [15:0] res;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 0;
    logic        rst;
    logic        rsp_ready;
    logic [7:0]  req_a, req_b;
    logic [2:0]  req_mode;

    logic        req_valid0, req_ready0, rsp_valid0, busy0;
    logic [7:0]  alu_a0, alu_b0;
    logic [2:0]  alu_mode0;
    logic [15:0] alu_result0, rsp_result0;

    logic        req_valid1, req_ready1, rsp_valid1, busy1;
    logic [7:0]  alu_a1, alu_b1;
    logic [2:0]  alu_mode1;
    logic [15:0] alu_result1, rsp_result1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] alu_f(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [2:0] m
    );
        logic [15:0] wa, wb;
        wa = {8'h00, a};
        wb = {8'h00, b};
        case (m)
            3'b001:  return wa - wb;
            3'b010:  return wa & wb;
            3'b011:  return wa | wb;
            3'b100:  return wa ^ wb;
            3'b101:  return wa << 1;
            3'b110:  return wa >> 1;
            default: return wa + wb;
        endcase
    endfunction

    assign alu_result0 = alu_f(alu_a0, alu_b0, alu_mode0);
    assign alu_result1 = alu_f(alu_a1, alu_b1, alu_mode1);

    alu_sequencer #(.MUL_EN(1)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid0),
        .req_ready  (req_ready0),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_mode   (req_mode),
        .alu_a      (alu_a0),
        .alu_b      (alu_b0),
        .alu_mode   (alu_mode0),
        .alu_result (alu_result0),
        .rsp_valid  (rsp_valid0),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result0),
        .busy       (busy0)
    );

    alu_sequencer #(.MUL_EN(0)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid1),
        .req_ready  (req_ready1),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_mode   (req_mode),
        .alu_a      (alu_a1),
        .alu_b      (alu_b1),
        .alu_mode   (alu_mode1),
        .alu_result (alu_result1),
        .rsp_valid  (rsp_valid1),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result1),
        .busy       (busy1)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitors: compare on every response handshake, sampled at negedge
    logic        v0_prev = 0, v1_prev = 0;
    int          first0, first1;
    logic [15:0] hold0, hold1;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            v0_prev = 0;
        end else begin
            if (rsp_valid0 && !v0_prev) begin
                first0 = cyc;
                hold0  = rsp_result0;
            end else if (rsp_valid0) begin
                chk("d0_stable", rsp_result0, hold0);
            end
            v0_prev = rsp_valid0;
            if (rsp_valid0 && rsp_ready) begin
                if (q0.size() == 0) begin
                    chk("d0_unexpected_rsp", 1, 0);
                end else begin
                    e = q0.pop_front();
                    chk(e.name, rsp_result0, e.res);
                    chk({e.name, "_lat"}, first0, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            v1_prev = 0;
        end else begin
            if (rsp_valid1 && !v1_prev) begin
                first1 = cyc;
                hold1  = rsp_result1;
            end else if (rsp_valid1) begin
                chk("d1_stable", rsp_result1, hold1);
            end
            v1_prev = rsp_valid1;
            if (rsp_valid1 && rsp_ready) begin
                if (q1.size() == 0) begin
                    chk("d1_unexpected_rsp", 1, 0);
                end else begin
                    e = q1.pop_front();
                    chk(e.name, rsp_result1, e.res);
                    chk({e.name, "_lat"}, first1, e.cyc);
                end
            end
        end
    end

    // Issue one request; returns at posedge+1 of the cycle after accept
    task automatic send(
        input int          which,
        input logic [7:0]  a,
        input logic [7:0]  b,
        input logic [2:0]  m,
        input logic [15:0] exp,
        input int          lat,
        input string       nm
    );
        int   n;
        logic rdy;
        exp_t e;
        req_a    = a;
        req_b    = b;
        req_mode = m;
        if (which == 0) req_valid0 = 1;
        else            req_valid1 = 1;
        n = 0;
        forever begin
            @(negedge clk);
            rdy = (which == 0) ? req_ready0 : req_ready1;
            if (rdy) break;
            n++;
            if (n > 40) begin
                chk({nm, "_accept_timeout"}, 1, 0);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (rdy) begin
            e.res  = exp;
            e.cyc  = cyc + lat;
            e.name = nm;
            if (which == 0) q0.push_back(e);
            else            q1.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid0 = 0;
        req_valid1 = 0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) chk({nm, "_drain_timeout"}, 1, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1;
        req_valid0 = 0;
        req_valid1 = 0;
        rsp_ready  = 1;
        req_a      = 0;
        req_b      = 0;
        req_mode   = 0;

        // Reset state, with req_valid held to show it is ignored
        repeat (2) @(posedge clk);
        #1;
        req_valid0 = 1;
        req_valid1 = 1;
        req_a      = 8'h11;
        @(negedge clk);
        chk("rst_req_ready", req_ready0, 1);
        chk("rst_busy", busy0, 0);
        chk("rst_rsp_valid", rsp_valid0, 0);
        chk("rst_rsp_result", rsp_result0, 0);
        chk("rst_alu_a", alu_a0, 0);
        chk("rst_alu_b", alu_b0, 0);
        chk("rst_alu_mode", alu_mode0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_no_accept", busy0, 0);
        chk("rst_no_accept1", busy1, 0);
        @(posedge clk);
        #1;
        req_valid0 = 0;
        req_valid1 = 0;
        rst        = 0;
        @(negedge clk);
        chk("post_rst_idle", busy0, 0);
        @(posedge clk);
        #1;

        // ALU modes through DRIVE
        send(0, 8'hFF, 8'h01, 3'b000, 16'h0100, 2, "add");
        drain("add");
        send(0, 8'h05, 8'h07, 3'b001, 16'hFFFE, 2, "sub");
        drain("sub");
        send(0, 8'h81, 8'h00, 3'b101, 16'h0102, 2, "shl");
        drain("shl");
        send(0, 8'h81, 8'h00, 3'b110, 16'h0040, 2, "shr");
        drain("shr");
        send(0, 8'hF0, 8'h3C, 3'b010, 16'h0030, 2, "and");
        drain("and");
        send(0, 8'hF0, 8'h0F, 3'b011, 16'h00FF, 2, "or");
        drain("or");
        send(0, 8'hAA, 8'hFF, 3'b100, 16'h0055, 2, "xor");
        drain("xor");

        // Back-to-back issue: one every 3 cycles
        send(0, 8'h01, 8'h02, 3'b000, 16'h0003, 2, "b2b_1");
        send(0, 8'h10, 8'h01, 3'b001, 16'h000F, 2, "b2b_2");
        drain("b2b");

        // Multiplier
        send(0, 8'hFF, 8'hFF, 3'b111, 16'hFE01, 9, "mul_ff");
        drain("mul_ff");
        send(0, 8'h00, 8'hFF, 3'b111, 16'h0000, 9, "mul_0");
        drain("mul_0");
        send(0, 8'h0D, 8'h0B, 3'b111, 16'h008F, 9, "mul_d_b");
        drain("mul_d_b");
        send(0, 8'h80, 8'h80, 3'b111, 16'h4000, 9, "mul_80");
        drain("mul_80");

        // Backpressure with a second request waiting throughout
        rsp_ready = 0;
        send(0, 8'h10, 8'h20, 3'b000, 16'h0030, 2, "bp1");
        req_a      = 8'h01;
        req_b      = 8'h01;
        req_mode   = 3'b000;
        req_valid0 = 1;
        @(negedge clk);
        chk("bp_drive_ready", req_ready0, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req_ready", req_ready0, 0);
            chk("bp_rsp_valid", rsp_valid0, 1);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1;
        @(negedge clk);
        chk("bp_hs_ready", req_ready0, 0);
        @(negedge clk);
        chk("bp_idle_ready", req_ready0, 1);
        begin
            exp_t e;
            e.res  = 16'h0002;
            e.cyc  = cyc + 2;
            e.name = "bp2";
            q0.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid0 = 0;
        drain("bp");

        // Reset in the fourth MUL cycle drops the transaction
        send(0, 8'h37, 8'h55, 3'b111, 16'h1243, 9, "mul_abort");
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy_before", busy0, 1);
        rst = 1;
        #1;
        chk("abort_rsp_valid", rsp_valid0, 0);
        chk("abort_busy", busy0, 0);
        chk("abort_req_ready", req_ready0, 1);
        chk("abort_alu_a", alu_a0, 0);
        chk("abort_alu_b", alu_b0, 0);
        chk("abort_alu_mode", alu_mode0, 0);
        chk("abort_rsp_result", rsp_result0, 0);
        q0.delete();
        @(posedge clk);
        #1;
        rst = 0;
        send(0, 8'h03, 8'h04, 3'b000, 16'h0007, 2, "add_after_rst");
        drain("add_after_rst");
        repeat (12) @(posedge clk);
        #1;

        // MUL_EN=0: mode 111 goes to the ALU, which adds by default
        send(1, 8'h02, 8'h03, 3'b111, 16'h0005, 2, "nomul");
        chk("nomul_alu_mode", alu_mode1, 3'b111);
        chk("nomul_alu_a", alu_a1, 8'h02);
        chk("nomul_alu_b", alu_b1, 8'h03);
        drain("nomul");
        chk("nomul_hold_mode", alu_mode1, 3'b111);

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MUL_EN, default 1: 1 enables the internal 8x8 unsigned multiply for mode 3'b111; 0 passes mode 3'b111 to the ALU unchanged.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  block accepts a request this cycle.
REQ-006 req_a, req_b  input  8 each  operands.
REQ-007 req_mode  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl1(a), 110 shr1(a), 111 mul.
REQ-008 alu_a, alu_b  output  8 each  operand drive to the combinational ALU.
REQ-009 alu_mode  output  3  mode drive to the ALU.
REQ-010 alu_result  input  16  combinational ALU result.
REQ-011 rsp_valid  output  1  result available.
REQ-012 rsp_ready  input  1  consumer accepts the result.
REQ-013 rsp_result  output  16  result.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states: IDLE, DRIVE, MUL, RESP; req_ready SHALL be 1 only in IDLE, with no request overlap.
REQ-016 IDLE: on req_valid&&req_ready, latch req_a/req_b/req_mode into operand registers; next state MUL if req_mode==111 and MUL_EN==1, else DRIVE.
REQ-017 alu_a/alu_b/alu_mode SHALL be driven directly from the operand registers, stable from the accept edge until the next accept; values hold in IDLE.
REQ-018 DRIVE lasts exactly one cycle; at its closing edge capture alu_result into rsp_result; next state RESP.
REQ-019 Latency: handshake in cycle k -> rsp_valid high in cycle k+2 (non-mul); k+9 (mul).
REQ-020 MUL: 3-bit counter 0..7, 16-bit accumulator cleared on accept; each cycle acc += b[cnt] ? (a << cnt) : 0; after cnt==7 load acc into rsp_result; next state RESP.
REQ-021 MUL result is the exact unsigned 16-bit product; no overflow is possible.
REQ-022 With MUL_EN==0, mode 111 goes through DRIVE with alu_mode=111 and returns whatever alu_result carries.
REQ-023 RESP: rsp_valid=1; rsp_result held stable until rsp_valid&&rsp_ready; then next state IDLE, with rsp_valid low in the following cycle.
REQ-024 req_valid outside IDLE SHALL be ignored with no state change; req_* need not be held.
REQ-025 Throughput: at most one transaction per 3 cycles (non-mul) or 10 cycles (mul) with rsp_ready tied high.

Reset
REQ-026 rst asserted at any time SHALL immediately force: state IDLE, req_ready=1, busy=0, rsp_valid=0, rsp_result=0, alu_a=0, alu_b=0, alu_mode=000, counter=0, accumulator=0.
REQ-027 An in-flight transaction aborted by reset SHALL be dropped, never replayed or responded to.
REQ-028 While rst is high, req_valid SHALL NOT be accepted.

Structure
REQ-029 Shared package alu_pkg SHALL hold the 3-bit mode constants (MODE_ADD .. MODE_MUL) and the FSM state enum.
REQ-030 The shift-add multiplier (counter, accumulator, done flag) SHALL be a sub-module named alu_mul_seq; the FSM stays in alu_sequencer.
REQ-031 The bench SHALL connect alu_a/alu_b/alu_mode/alu_result to the team's 8-bit ALU.

Verification
REQ-032 Add: reset, then req a=8'hFF b=8'h01 mode=000, rsp_ready=1 -> rsp_valid at k+2, rsp_result=16'h0100.
REQ-033 Sub: a=8'h05 b=8'h07 mode=001 -> rsp_result=16'hFFFE; shl: a=8'h81 mode=101 -> 16'h0102.
REQ-034 Mul: a=8'hFF b=8'hFF mode=111, MUL_EN=1 -> rsp_valid at k+9, rsp_result=16'hFE01; a=8'h00 -> 16'h0000.
REQ-035 Backpressure: rsp_ready low for 5 cycles with req_valid=1 throughout -> rsp_result stable, req_ready=0, no second accept; accept occurs in the first IDLE cycle after the response handshake.
REQ-036 Reset mid-op: assert rst in MUL cycle 4 -> same cycle rsp_valid=0, busy=0, req_ready=1, alu_* = 0; after release, a new add of 3+4 returns 16'h0007.
REQ-037 MUL_EN=0: a=8'h02 b=8'h03 mode=111 -> alu_mode=111, rsp_result=16'h0005 (ALU default add), latency k+2.
